// File: rtl/hamming_scrubber.sv
// hamming_scrubber
//   Background scrubber for a single-error-correcting Hamming-coded memory. A pass walks
//   addresses 0..depth-1, reads each codeword, computes its syndrome and, if non-zero, writes
//   back the word with the faulty bit flipped. Host accesses are forwarded to the memory
//   whenever the scrubber is not in the middle of a read-check-write of one word.
//
//   Optional build macro: HAMMING_SCRUB_AUTO_EN
//     defined   -> scrubs continuously out of reset, start is ignored
//     undefined -> a pass runs only on a start pulse
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse requesting a scrub pass
//   host_*          host access request (req/we/addr/wdata)
//   host_gnt        host access forwarded to memory this cycle
//   mem_*           memory strobes, address and write data; mem_rdata valid 1 cycle after read
//   busy, done      pass in progress / one-cycle end-of-pass pulse
//   corr_count      saturating count of corrected words since reset
//   last_err_addr   address of the most recent correction
module hamming_scrubber #(
    parameter int unsigned parity_bits = 4,
    parameter int unsigned total_width = (1 << parity_bits) - 1,
    parameter int unsigned depth       = 16,
    localparam int unsigned addr_w     = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [addr_w-1:0]      host_addr,
    input  logic [total_width:1]   host_wdata,
    output logic                   host_gnt,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [addr_w-1:0]      mem_addr,
    output logic [total_width:1]   mem_wdata,
    input  logic [total_width:1]   mem_rdata,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            corr_count,
    output logic [addr_w-1:0]      last_err_addr
);

    localparam logic [addr_w-1:0] LastAddr = addr_w'(depth - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCheck,
        StWrite,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [addr_w-1:0]      scrub_addr_q, scrub_addr_d;
    logic [total_width:1]   word_q, word_d;
    logic [15:0]            corr_count_q, corr_count_d;
    logic [addr_w-1:0]      last_err_addr_q, last_err_addr_d;

    logic [parity_bits-1:0] syndrome;
    logic [total_width:1]   corrected;
    logic                   host_ok;
    logic                   at_last;

    // Syndrome is the XOR of the positions of all set bits; it names the bit to flip.
    always_comb begin
        syndrome = '0;
        for (int unsigned i = 1; i <= total_width; i++) begin
            if (mem_rdata[i]) begin
                syndrome = syndrome ^ parity_bits'(i);
            end
        end
        corrected = mem_rdata;
        for (int unsigned i = 1; i <= total_width; i++) begin
            if (i == 32'(syndrome)) begin
                corrected[i] = ~mem_rdata[i];
            end
        end
    end

    // Gating with rst_n keeps the host path silent while reset is held.
    assign host_ok = host_req & rst_n;
    assign at_last = (scrub_addr_q == LastAddr);

    always_comb begin
        state_d         = state_q;
        scrub_addr_d    = scrub_addr_q;
        word_d          = word_q;
        corr_count_d    = corr_count_q;
        last_err_addr_d = last_err_addr_q;
        host_gnt        = 1'b0;
        mem_rd_en       = 1'b0;
        mem_wr_en       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        busy            = 1'b0;
        done            = 1'b0;

        unique case (state_q)
            StIdle: begin
                host_gnt = host_ok;
`ifdef HAMMING_SCRUB_AUTO_EN
                scrub_addr_d = '0;
                state_d      = StRead;
`else
                if (start) begin
                    scrub_addr_d = '0;
                    state_d      = StRead;
                end
`endif
            end
            StRead: begin
                busy     = 1'b1;
                host_gnt = host_ok;
                // Host has absolute priority; the scrub read simply waits.
                if (!host_ok) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = scrub_addr_q;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                busy     = 1'b1;
                mem_addr = scrub_addr_q;
                if (syndrome != '0) begin
                    word_d  = corrected;
                    state_d = StWrite;
                end else if (at_last) begin
                    state_d = StDone;
                end else begin
                    scrub_addr_d = scrub_addr_q + 1'b1;
                    state_d      = StRead;
                end
            end
            StWrite: begin
                busy            = 1'b1;
                mem_wr_en       = 1'b1;
                mem_addr        = scrub_addr_q;
                mem_wdata       = word_q;
                corr_count_d    = (corr_count_q == 16'hFFFF) ? corr_count_q : corr_count_q + 16'd1;
                last_err_addr_d = scrub_addr_q;
                if (at_last) begin
                    state_d = StDone;
                end else begin
                    scrub_addr_d = scrub_addr_q + 1'b1;
                    state_d      = StRead;
                end
            end
            StDone: begin
                done     = 1'b1;
                host_gnt = host_ok;
`ifdef HAMMING_SCRUB_AUTO_EN
                scrub_addr_d = '0;
                state_d      = StRead;
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_rd_en = ~host_we;
            mem_wr_en = host_we;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            scrub_addr_q    <= '0;
            word_q          <= '0;
            corr_count_q    <= '0;
            last_err_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            scrub_addr_q    <= scrub_addr_d;
            word_q          <= word_d;
            corr_count_q    <= corr_count_d;
            last_err_addr_q <= last_err_addr_d;
        end
    end

    assign corr_count    = corr_count_q;
    assign last_err_addr = last_err_addr_q;

endmodule
